// File: rtl/flexbus_initiator_if.sv
// rtl/flexbus_initiator_if.sv - command/response and FlexBus pin bundle for the initiator
//
// Purpose: groups the command channel, the response channel and the FlexBus
//   pins of one initiator so they travel as a single port.
// Modports:
//   master - the initiator side (drives cmd_ready, rsp_*, all bus outputs)
//   slave  - the user/target side (drives cmd_*, FB_AD_I, bFB_TA)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_be  command request
//   rsp_valid/rsp_rdata/rsp_err                              completion
//   FB_AD_O/FB_AD_OE/FB_AD_I                                 muxed address/data
//   bFB_CS/bFB_BE/bFB_OE/FB_RbW/FB_ALE/FB_TSIZ/bFB_TBST      bus controls
//   bFB_TA                                                   target acknowledge
interface flexbus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] FB_AD_O;
  logic        FB_AD_OE;
  logic [31:0] FB_AD_I;
  logic [5:0]  bFB_CS;
  logic [3:0]  bFB_BE;
  logic        bFB_OE;
  logic        FB_RbW;
  logic        FB_ALE;
  logic [1:0]  FB_TSIZ;
  logic        bFB_TBST;
  logic        bFB_TA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, FB_AD_I, bFB_TA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, FB_AD_O, FB_AD_OE,
           bFB_CS, bFB_BE, bFB_OE, FB_RbW, FB_ALE, FB_TSIZ, bFB_TBST
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, FB_AD_I, bFB_TA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, FB_AD_O, FB_AD_OE,
           bFB_CS, bFB_BE, bFB_OE, FB_RbW, FB_ALE, FB_TSIZ, bFB_TBST
  );
endinterface

// File: rtl/flexbus_initiator.sv
// rtl/flexbus_initiator.sv - FlexBus single-beat 32-bit multiplexed bus master
//
// Purpose: turns one command into an IDLE -> ADDR -> DATA -> HOLD FlexBus
//   cycle on chip select CS_INDEX, waits for bFB_TA in DATA and reports
//   completion (and read data) with a one-cycle rsp_valid pulse.
// Ports:
//   FB_CLK  - bus clock, rising edge
//   FB_RST  - synchronous active-high reset
//   bus     - flexbus_initiator_if.master (command, response and bus pins)
// Configuration:
//   FLEXBUS_TIMEOUT_EN - when defined, DATA aborts after TIMEOUT_CYCLES cycles
//                        without acknowledge and the response carries rsp_err=1.
module flexbus_initiator #(
  parameter int unsigned CS_INDEX       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 FB_CLK,
  input  logic                 FB_RST,
  flexbus_initiator_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_e;

  localparam logic [5:0] CS_SEL = ~(6'(1) << CS_INDEX);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] ad_o_q, ad_o_d;
  logic        ad_oe_q, ad_oe_d;
  logic [5:0]  cs_q, cs_d;
  logic [3:0]  be_n_q, be_n_d;
  logic        oe_n_q, oe_n_d;
  logic        rbw_q, rbw_d;
  logic        ale_q, ale_d;

  logic accept;
  logic ta;
  logic timeout_hit;

  // cmd_ready_q is only ever high while the FSM sits in IDLE
  assign accept = bus.cmd_valid && cmd_ready_q;
  assign ta     = (state_q == DATA) && !bus.bFB_TA;

`ifdef FLEXBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter rests at zero outside DATA, so it starts from zero on every entry.
  assign cnt_d       = (state_q == DATA) ? cnt_q + CNT_W'(1) : '0;
  assign timeout_hit = (state_q == DATA) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge FB_CLK) begin
    if (FB_RST) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and command/response datapath
  always_ff @(posedge FB_CLK) begin
    if (FB_RST) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ad_o_q      <= '0;
      ad_oe_q     <= 1'b0;
      cs_q        <= 6'h3F;
      be_n_q      <= 4'hF;
      oe_n_q      <= 1'b1;
      rbw_q       <= 1'b1;
      ale_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ad_o_q      <= ad_o_d;
      ad_oe_q     <= ad_oe_d;
      cs_q        <= cs_d;
      be_n_q      <= be_n_d;
      oe_n_q      <= oe_n_d;
      rbw_q       <= rbw_d;
      ale_q       <= ale_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = ADDR;
        write_d = bus.cmd_write;
        addr_d  = bus.cmd_addr;
        wdata_d = bus.cmd_wdata;
        be_d    = bus.cmd_be;
      end
      ADDR: state_d = DATA;
      DATA: if (ta || timeout_hit) state_d = HOLD;
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the state being entered so the registered
  // pins line up with state_q; TA on the terminal-count edge beats timeout.
  always_comb begin
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = (ta && !write_q) ? bus.FB_AD_I : rsp_rdata_q;
    ad_o_d      = '0;
    ad_oe_d     = 1'b0;
    cs_d        = 6'h3F;
    be_n_d      = 4'hF;
    oe_n_d      = 1'b1;
    rbw_d       = 1'b1;
    ale_d       = 1'b0;
    unique case (state_d)
      IDLE: cmd_ready_d = 1'b1;
      ADDR: begin
        ale_d   = 1'b1;
        ad_o_d  = addr_d;
        ad_oe_d = 1'b1;
        rbw_d   = ~write_d;
      end
      DATA: begin
        cs_d   = CS_SEL;
        be_n_d = ~be_d;
        rbw_d  = ~write_d;
        if (write_d) begin
          ad_o_d  = wdata_d;
          ad_oe_d = 1'b1;
        end else begin
          oe_n_d = 1'b0;
        end
      end
      HOLD: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = timeout_hit && !ta;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.FB_AD_O   = ad_o_q;
  assign bus.FB_AD_OE  = ad_oe_q;
  assign bus.bFB_CS    = cs_q;
  assign bus.bFB_BE    = be_n_q;
  assign bus.bFB_OE    = oe_n_q;
  assign bus.FB_RbW    = rbw_q;
  assign bus.FB_ALE    = ale_q;
  assign bus.FB_TSIZ   = 2'b00;
  assign bus.bFB_TBST  = 1'b1;

endmodule

// File: tb/tb_flexbus_initiator.sv
// tb/tb_flexbus_initiator.sv - scoreboard bench for flexbus_initiator
module tb_flexbus_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t sb_q[$];
  int   ale_q[$];

  int          tgt_n = 0;
  int          tgt_waits = 0;
  bit          tgt_never = 1'b0;
  bit          tgt_force = 1'b0;
  logic [31:0] last_rdata = '0;

  flexbus_initiator_if bus_if ();

  flexbus_initiator #(.CS_INDEX(1), .TIMEOUT_CYCLES(8)) dut (
    .FB_CLK (clk),
    .FB_RST (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus_if.FB_ALE) ale_q.push_back(cyc);
    if (bus_if.rsp_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want 0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", bus_if.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("hold_ad_oe", 32'(bus_if.FB_AD_OE), 32'd0);
        chk("hold_cs", 32'(bus_if.bFB_CS), 32'h3F);
      end
    end
  end

  // Target model: acknowledges after tgt_waits DATA cycles on chip select 1.
  initial begin
    bus_if.bFB_TA  = 1'b1;
    bus_if.FB_AD_I = '0;
    forever begin
      @(negedge clk);
      if (!bus_if.bFB_CS[1]) begin
        bus_if.bFB_TA = (!tgt_never && tgt_n == tgt_waits) ? 1'b0 : 1'b1;
        tgt_n++;
      end else begin
        tgt_n = 0;
        bus_if.bFB_TA = tgt_force ? 1'b0 : 1'b1;
      end
    end
  end

  // Returns just after the acceptance edge; cmd_valid is left high.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int waits, input bit never,
                       input bit exp_rsp, input logic [31:0] exp_rd,
                       input bit exp_err, input int exp_lat);
    exp_t e;
    int   guard;
    @(negedge clk);
    bus_if.cmd_write = wr;
    bus_if.cmd_addr  = a;
    bus_if.cmd_wdata = d;
    bus_if.cmd_be    = be;
    bus_if.cmd_valid = 1'b1;
    tgt_waits = waits;
    tgt_never = never;
    guard = 0;
    while (!bus_if.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept", 32'(bus_if.cmd_ready), 32'd1);
    if (exp_rsp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.acc   = cyc + 1;
      e.lat   = exp_lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_cnt;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.cmd_be    = '0;

    // Reset state
    idle_cycles(3);
    chk("rst_cs", 32'(bus_if.bFB_CS), 32'h3F);
    chk("rst_be", 32'(bus_if.bFB_BE), 32'hF);
    chk("rst_oe", 32'(bus_if.bFB_OE), 32'd1);
    chk("rst_rbw", 32'(bus_if.FB_RbW), 32'd1);
    chk("rst_ale", 32'(bus_if.FB_ALE), 32'd0);
    chk("rst_ad_oe", 32'(bus_if.FB_AD_OE), 32'd0);
    chk("rst_ad_o", bus_if.FB_AD_O, 32'd0);
    chk("rst_tsiz", 32'(bus_if.FB_TSIZ), 32'd0);
    chk("rst_tbst", 32'(bus_if.bFB_TBST), 32'd1);
    chk("rst_ready", 32'(bus_if.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_rdata", bus_if.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus_if.rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus_if.cmd_ready), 32'd1);

    // Write, zero wait states
    issue(1'b1, 32'h02000001, 32'h3F800000, 4'hF, 0, 1'b0, 1'b1, last_rdata, 1'b0, 3);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    chk("wr_addr_ale", 32'(bus_if.FB_ALE), 32'd1);
    chk("wr_addr_ad", bus_if.FB_AD_O, 32'h02000001);
    chk("wr_addr_ad_oe", 32'(bus_if.FB_AD_OE), 32'd1);
    chk("wr_addr_rbw", 32'(bus_if.FB_RbW), 32'd0);
    chk("wr_addr_cs", 32'(bus_if.bFB_CS), 32'h3F);
    @(negedge clk);
    chk("wr_data_cs", 32'(bus_if.bFB_CS), 32'h3D);
    chk("wr_data_ad", bus_if.FB_AD_O, 32'h3F800000);
    chk("wr_data_ale", 32'(bus_if.FB_ALE), 32'd0);
    chk("wr_data_be", 32'(bus_if.bFB_BE), 32'h0);
    chk("wr_data_oe", 32'(bus_if.bFB_OE), 32'd1);
    idle_cycles(3);

    // Read, two wait states
    bus_if.FB_AD_I = 32'h12345678;
    issue(1'b0, 32'h02000008, 32'h0, 4'hF, 2, 1'b0, 1'b1, 32'h12345678, 1'b0, 5);
    oe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      if (i == 0) chk("rd_addr_rbw", 32'(bus_if.FB_RbW), 32'd1);
      if (!bus_if.bFB_OE) begin
        oe_cnt++;
        chk("rd_data_ad_oe", 32'(bus_if.FB_AD_OE), 32'd0);
      end
    end
    chk("rd_oe_cycles", 32'(oe_cnt), 32'd3);
    last_rdata = 32'h12345678;

    // Write with partial byte enables, one wait state
    issue(1'b1, 32'h02000010, 32'hA5A50F0F, 4'h5, 1, 1'b0, 1'b1, last_rdata, 1'b0, 4);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pbe_be", 32'(bus_if.bFB_BE), 32'hA);
    chk("pbe_tsiz", 32'(bus_if.FB_TSIZ), 32'd0);
    chk("pbe_tbst", 32'(bus_if.bFB_TBST), 32'd1);
    idle_cycles(4);

    // Back-to-back writes with cmd_valid held
    ale_q.delete();
    issue(1'b1, 32'h02000100, 32'h11111111, 4'hF, 0, 1'b0, 1'b1, last_rdata, 1'b0, 3);
    issue(1'b1, 32'h02000104, 32'h22222222, 4'hF, 0, 1'b0, 1'b1, last_rdata, 1'b0, 3);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    idle_cycles(5);
    chk("b2b_ale_count", 32'(ale_q.size()), 32'd2);
    if (ale_q.size() == 2) chk("b2b_ale_gap", 32'(ale_q[1] - ale_q[0]), 32'd4);

    // TA held low while idle
    tgt_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_ta_ready", 32'(bus_if.cmd_ready), 32'd1);
      chk("idle_ta_cs", 32'(bus_if.bFB_CS), 32'h3F);
    end
    tgt_force = 1'b0;

    // Reset during DATA of a read
    bus_if.FB_AD_I = 32'h55AA55AA;
    issue(1'b0, 32'h02000020, 32'h0, 4'hF, 5, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstd_in_data", 32'(bus_if.bFB_OE), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstd_cs", 32'(bus_if.bFB_CS), 32'h3F);
    chk("rstd_oe", 32'(bus_if.bFB_OE), 32'd1);
    chk("rstd_rdata", bus_if.rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstd_ready", 32'(bus_if.cmd_ready), 32'd1);
    last_rdata = 32'h0;
    idle_cycles(10);

`ifdef FLEXBUS_TIMEOUT_EN
    // Target never acknowledges: abort after 8 DATA cycles
    bus_if.FB_AD_I = 32'hDEADBEEF;
    issue(1'b0, 32'h02000030, 32'h0, 4'hF, 0, 1'b1, 1'b1, last_rdata, 1'b1, 10);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    idle_cycles(14);
    // Acknowledge on the 8th DATA cycle wins over the timeout
    bus_if.FB_AD_I = 32'hCAFEF00D;
    issue(1'b0, 32'h02000034, 32'h0, 4'hF, 7, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 10);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    idle_cycles(14);
`else
    // Without the timeout a long wait still completes cleanly
    bus_if.FB_AD_I = 32'hCAFEF00D;
    issue(1'b0, 32'h02000034, 32'h0, 4'hF, 12, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 15);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    idle_cycles(18);
`endif

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
